// File: rtl/tape_reader_pkg.sv
// Shared constants and state encodings for the paper-tape reader emulator.
package tape_reader_pkg;

  localparam logic [6:0] ASCII_XON  = 7'h11;
  localparam logic [6:0] ASCII_XOFF = 7'h13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_SEND,
    ST_PAUSE,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // The CPU transmits mark parity, so bit 7 never takes part in the match.
  function automatic logic ctrl_match(input logic [7:0] b, input logic [6:0] code);
    return (b & 8'h7F) == {1'b0, code};
  endfunction

endpackage

// File: rtl/tape_reader_uart_rx_sync.sv
// Flow-control receiver: synchronizes rxd, qualifies the start bit at
// mid-bit, samples 8 data bits plus the stop bit, and drops framing errors.
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the synchronized line
// RX_START | counting to mid start bit; high there means it was a glitch
// RX_DATA  | sampling 8 data bits LSB-first, one per bit period
// RX_STOP  | sampling the stop bit; only a high stop bit yields rx_valid
module uart_rx_sync
  import tape_reader_pkg::*;
#(
  parameter int DIVISOR = 10417
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rxd,
  output logic       rx_valid,
  output logic [7:0] rx_byte
);

  localparam int            CW          = $clog2(DIVISOR);
  localparam logic [CW-1:0] BAUD_RELOAD = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(DIVISOR / 2 - 1);

  rx_state_e     state_q, state_d;
  logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;

  // Synchronizer, edge detector and bit sampler next-state logic.
  always_comb begin
    sync1_d = rxd;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    valid_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          cnt_d   = HALF_RELOAD;
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (sync2_q) begin
          state_d = RX_IDLE;
        end else begin
          cnt_d   = BAUD_RELOAD;
          bit_d   = 3'd7;
          state_d = RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          data_d = {sync2_q, data_q[7:1]};
          cnt_d  = BAUD_RELOAD;
          if (bit_q == 3'd0) state_d = RX_STOP;
          else               bit_d   = bit_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          valid_d = sync2_q;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Receiver registers; the synchronizer resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= RX_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign rx_valid = valid_q;
  assign rx_byte  = data_q;

endmodule

// File: rtl/tape_reader.sv
// Paper-tape reader emulator: streams an image as async frames on txd and
// honours XON/XOFF received on rxd at frame boundaries.
//
// state    | meaning
// ST_IDLE  | waiting for start; start latches length and clears index/xoff
// ST_FETCH | rd_addr presents the current index to the image memory
// ST_LATCH | image byte captured into the frame shifter
// ST_SEND  | start bit, 8 data bits LSB-first, stop bits; DIVISOR cycles each
// ST_PAUSE | XOFF in effect between frames; txd held high
// ST_DONE  | one-cycle done pulse, then back to idle
module tape_reader
  import tape_reader_pkg::*;
#(
  parameter int DIVISOR   = 10417,
  parameter int STOP_BITS = 2,
  parameter int AW        = 12
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [AW-1:0] length,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  input  logic          rxd,
  output logic          txd,
  output logic          busy,
  output logic          paused,
  output logic          done
);

  localparam int            CW          = $clog2(DIVISOR);
  localparam logic [CW-1:0] BAUD_RELOAD = CW'(DIVISOR - 1);
  // Index of the final stop bit when counting frame bits from zero.
  localparam logic [3:0]    LAST_BIT    = 4'(8 + STOP_BITS);

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d, len_q, len_d, idx_inc;
  logic [10:0]   shift_q, shift_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] baud_q, baud_d;
  logic          xoff_q, xoff_d, xoff_upd;
  logic          rx_valid;
  logic [7:0]    rx_byte;

  uart_rx_sync #(.DIVISOR(DIVISOR)) u_rx (
    .clk      (clk),
    .resetn   (resetn),
    .rxd      (rxd),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte)
  );

  assign idx_inc = idx_q + AW'(1);

  // Flow-control flag as it stands after this cycle's received byte.
  always_comb begin
    xoff_upd = xoff_q;
    if (rx_valid) begin
      if (ctrl_match(rx_byte, ASCII_XOFF))     xoff_upd = 1'b1;
      else if (ctrl_match(rx_byte, ASCII_XON)) xoff_upd = 1'b0;
    end
  end

  // Main sequencer and transmit shifter next-state logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    xoff_d  = xoff_upd;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = length;
          idx_d   = '0;
          xoff_d  = 1'b0;
          state_d = (length == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        shift_d = {2'b11, rd_data, 1'b0};
        bit_d   = LAST_BIT;
        baud_d  = BAUD_RELOAD;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (baud_q != '0) begin
          baud_d = baud_q - 1'b1;
        end else if (bit_q != 4'd0) begin
          shift_d = {1'b1, shift_q[10:1]};
          bit_d   = bit_q - 1'b1;
          baud_d  = BAUD_RELOAD;
        end else begin
          idx_d = idx_inc;
          if (idx_inc == len_q) state_d = ST_DONE;
          else if (xoff_upd)    state_d = ST_PAUSE;
          else                  state_d = ST_FETCH;
        end
      end
      ST_PAUSE: begin
        if (!xoff_q) state_d = ST_FETCH;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      shift_q <= '1;
      bit_q   <= '0;
      baud_q  <= '0;
      xoff_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      xoff_q  <= xoff_d;
    end
  end

  assign rd_addr = idx_q;
  assign txd     = (state_q == ST_SEND) ? shift_q[0] : 1'b1;
  assign busy    = (state_q == ST_FETCH) || (state_q == ST_LATCH) ||
                   (state_q == ST_SEND)  || (state_q == ST_PAUSE);
  assign paused  = (state_q == ST_PAUSE);
  assign done    = (state_q == ST_DONE);

endmodule
